// File: rtl/cell2_truth_checker.sv
// Exhaustive self-check harness for a 2-input library cell: drives all four input
// vectors per sweep, samples the cell output after a settle time and tallies mismatches.
module cell2_truth_checker #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 2
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_pass,
  output logic       drv_i0,
  output logic       drv_i1,
  input  logic       cut_nq,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [1:0] first_err_vec,
  output logic       first_err_valid
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  vec;
  logic [7:0]  sweep;
  logic [7:0]  n_pass_q;
  logic [3:0]  settle_cnt;
  logic [1:0]  drv;
  logic        settle_done;
  logic        last_vec;
  logic        last_sweep;
  logic        mismatch;
  logic [7:0]  err_cnt_next;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign last_vec    = (vec == 2'd3);
  assign last_sweep  = (sweep == n_pass_q - 8'd1);
  assign busy        = (state == APPLY) || (state == SAMPLE);
  assign done        = (state == FINISH);
  assign drv_i0      = drv[0];
  assign drv_i1      = drv[1];

  // Case inequality so an X/Z output from the cell in simulation counts as a failure.
  assign mismatch = (cut_nq !== TRUTH[vec]);

  always_comb begin
    err_cnt_next = err_cnt;
    if (state == SAMPLE && mismatch && err_cnt != 8'hFF)
      err_cnt_next = err_cnt + 8'd1;
  end

  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (n_pass == 8'd0) ? FINISH : APPLY;
      APPLY:   if (settle_done) state_next = SAMPLE;
      SAMPLE:  state_next = (last_vec && last_sweep) ? FINISH : APPLY;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector counter wraps 3 -> 0 naturally, which is also the first vector of the next sweep.
  always_ff @(posedge ck) begin
    if (rst) begin
      vec             <= 2'd0;
      sweep           <= 8'd0;
      n_pass_q        <= 8'd0;
      settle_cnt      <= 4'd0;
      drv             <= 2'd0;
      pass            <= 1'b0;
      err_cnt         <= 8'd0;
      first_err_vec   <= 2'd0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_cnt         <= 8'd0;
            first_err_vec   <= 2'd0;
            first_err_valid <= 1'b0;
            pass            <= (n_pass == 8'd0);
            n_pass_q        <= n_pass;
            vec             <= 2'd0;
            sweep           <= 8'd0;
            settle_cnt      <= 4'd0;
            drv             <= 2'd0;
          end
        end
        APPLY: begin
          settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
        end
        SAMPLE: begin
          err_cnt <= err_cnt_next;
          if (mismatch && !first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
          end
          if (last_vec && last_sweep) begin
            pass <= (err_cnt_next == 8'd0);
            drv  <= 2'd0;
          end else begin
            vec <= vec + 2'd1;
            drv <= vec + 2'd1;
            if (last_vec) sweep <= sweep + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell2_truth_checker.sv
// Directed bench for cell2_truth_checker using a behavioural cell model with selectable faults.
module tb_cell2_truth_checker;

  logic       ck = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] n_pass;
  logic       drv_i0, drv_i1;
  logic       cut_nq;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] first_err_vec;
  logic       first_err_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  // 0 = ideal nand2, 1 = stuck at 1, 2 = stuck at 0, 3 = and2
  int mode = 0;

  cell2_truth_checker #(.TRUTH(4'b0111), .SETTLE(2)) dut (
    .ck(ck), .rst(rst), .start(start), .n_pass(n_pass),
    .drv_i0(drv_i0), .drv_i1(drv_i1), .cut_nq(cut_nq),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  always #5 ck = ~ck;

  always_comb begin
    cut_nq = 1'b0;
    case (mode)
      0: cut_nq = ~(drv_i1 & drv_i0);
      1: cut_nq = 1'b1;
      2: cut_nq = 1'b0;
      default: cut_nq = drv_i1 & drv_i0;
    endcase
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // Issue start in the current cycle; returns positioned in cycle 1 of the run.
  task automatic start_run(input logic [7:0] n);
    start  = 1'b1;
    n_pass = n;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc <= limit) begin
      step();
      cyc++;
    end
    if (cyc > limit) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_pass = 8'd0;
    step(); step();
    tests_run++; if ({drv_i1, drv_i0} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_drv: got %b expected 00", {drv_i1, drv_i0}); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
    tests_run++; if (err_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    tests_run++; if ({first_err_valid, first_err_vec} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_first_err: got %b expected 000", {first_err_valid, first_err_vec}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ideal_nand();
    logic [1:0] exp_vec;
    mode = 0;
    start_run(8'd1);
    for (int c = 1; c <= 12; c++) begin
      exp_vec = 2'((c - 1) / 3);
      tests_run++; if ({drv_i1, drv_i0} !== exp_vec) begin tests_failed++; $display("[TB] FAIL nand_drive c%0d: got %b expected %b", c, {drv_i1, drv_i0}, exp_vec); end
      tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL nand_busy c%0d: got busy=%b done=%b expected busy=1 done=0", c, busy, done); end
      step();
    end
    tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL nand_done c13: got done=%b busy=%b expected done=1 busy=0", done, busy); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL nand_pass: got %b expected 1", pass); end
    tests_run++; if (err_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL nand_err_cnt: got %0d expected 0", err_cnt); end
    tests_run++; if (first_err_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL nand_first_valid: got %b expected 0", first_err_valid); end
    tests_run++; if ({drv_i1, drv_i0} !== 2'b00) begin tests_failed++; $display("[TB] FAIL nand_drive_finish: got %b expected 00", {drv_i1, drv_i0}); end
    step();
    tests_run++; if (done !== 1'b0 || pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL nand_hold: got done=%b pass=%b expected done=0 pass=1", done, pass); end
  endtask

  task automatic test_stuck_high();
    int cyc;
    mode = 1;
    start_run(8'd3);
    wait_done(60, cyc);
    tests_run++; if (cyc != 37) begin tests_failed++; $display("[TB] FAIL stuck1_done_cycle: got %0d expected 37", cyc); end
    tests_run++; if (err_cnt !== 8'd3) begin tests_failed++; $display("[TB] FAIL stuck1_err_cnt: got %0d expected 3", err_cnt); end
    tests_run++; if (first_err_vec !== 2'b11 || first_err_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stuck1_first_err: got vec=%b valid=%b expected vec=11 valid=1", first_err_vec, first_err_valid); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL stuck1_pass: got %b expected 0", pass); end
    step();
  endtask

  task automatic test_saturation();
    int cyc;
    mode = 2;
    start_run(8'd200);
    wait_done(2500, cyc);
    tests_run++; if (cyc != 2401) begin tests_failed++; $display("[TB] FAIL stuck0_done_cycle: got %0d expected 2401", cyc); end
    tests_run++; if (err_cnt !== 8'd255) begin tests_failed++; $display("[TB] FAIL stuck0_err_sat: got %0d expected 255", err_cnt); end
    tests_run++; if (first_err_vec !== 2'b00 || first_err_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stuck0_first_err: got vec=%b valid=%b expected vec=00 valid=1", first_err_vec, first_err_valid); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL stuck0_pass: got %b expected 0", pass); end
    step();
  endtask

  task automatic test_and2_and_zero();
    int cyc;
    mode = 3;
    start_run(8'd2);
    wait_done(40, cyc);
    tests_run++; if (cyc != 25) begin tests_failed++; $display("[TB] FAIL and2_done_cycle: got %0d expected 25", cyc); end
    tests_run++; if (err_cnt !== 8'd8) begin tests_failed++; $display("[TB] FAIL and2_err_cnt: got %0d expected 8", err_cnt); end
    tests_run++; if (first_err_vec !== 2'b00 || pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL and2_first_err: got vec=%b pass=%b expected vec=00 pass=0", first_err_vec, pass); end
    step();
    start_run(8'd0);
    tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_done_c1: got done=%b busy=%b expected done=1 busy=0", done, busy); end
    tests_run++; if (pass !== 1'b1 || err_cnt !== 8'd0 || first_err_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_results: got pass=%b err=%0d valid=%b expected pass=1 err=0 valid=0", pass, err_cnt, first_err_valid); end
    tests_run++; if ({drv_i1, drv_i0} !== 2'b00) begin tests_failed++; $display("[TB] FAIL zero_drive: got %b expected 00", {drv_i1, drv_i0}); end
    step();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_done_width: got %b expected 0", done); end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int done_at = -1;
    mode = 1;
    start_run(8'd1);
    for (int c = 1; c <= 20; c++) begin
      start = (c == 4 || c == 12 || c == 13);
      if (done === 1'b1) begin dones++; done_at = c; end
      step();
    end
    start = 1'b0;
    tests_run++; if (dones != 1 || done_at != 13) begin tests_failed++; $display("[TB] FAIL ignore_done: got count=%0d at=%0d expected count=1 at=13", dones, done_at); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ignore_idle: got busy=%b expected 0", busy); end
    tests_run++; if (err_cnt !== 8'd1 || first_err_vec !== 2'b11 || first_err_valid !== 1'b1 || pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL ignore_results: got err=%0d vec=%b valid=%b pass=%b expected 1 11 1 0", err_cnt, first_err_vec, first_err_valid, pass); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int dones = 0;
    int busies = 0;
    mode = 0;
    start_run(8'd1);
    for (int c = 1; c < 5; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++; if ({drv_i1, drv_i0} !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_ctrl: got drv=%b busy=%b done=%b expected 00 0 0", {drv_i1, drv_i0}, busy, done); end
    tests_run++; if (pass !== 1'b0 || err_cnt !== 8'd0 || first_err_vec !== 2'b00 || first_err_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_results: got pass=%b err=%0d vec=%b valid=%b expected 0 0 00 0", pass, err_cnt, first_err_vec, first_err_valid); end
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
      step();
    end
    tests_run++; if (dones != 0 || busies != 0) begin tests_failed++; $display("[TB] FAIL midrst_quiet: got dones=%0d busy_cycles=%0d expected 0 0", dones, busies); end
    start_run(8'd1);
    wait_done(20, cyc);
    tests_run++; if (cyc != 13 || pass !== 1'b1 || err_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL midrst_rerun: got cycle=%0d pass=%b err=%0d expected 13 1 0", cyc, pass, err_cnt); end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_pass = 8'd0;
    #1;
    test_reset();
    test_ideal_nand();
    test_stuck_high();
    test_saturation();
    test_and2_and_zero();
    test_start_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cell2_truth_checker.md
Name: cell2_truth_checker

Overview:
- Sequential self-check harness for 2-input combinational library cells (nand2 and siblings); it sits at the input/output pins of the cell under test (CUT).
- Drives exhaustive input vectors onto the CUT inputs and waits a programmable settle time.
- Samples the CUT output and compares it against a parameterised truth table.
- Reports pass/fail, a saturating mismatch count and the first failing vector via a start/done handshake.

Parameters:
- TRUTH, 4'b0111, expected CUT output indexed by {i1,i0}; default is nand2.
- SETTLE, 2, cycles each vector is held before the sample cycle; legal range 1..15.

Ports:
- ck  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  run request, accepted only in IDLE
- n_pass  input  8  number of full 4-vector sweeps; sampled on accepted start
- drv_i0  output  1  drives CUT input i0
- drv_i1  output  1  drives CUT input i1
- cut_nq  input  1  CUT output
- busy  output  1  high while vectors are applied or sampled
- done  output  1  one-cycle pulse at end of run
- pass  output  1  1 when err_cnt==0; valid from done until next accepted start
- err_cnt  output  8  mismatch count, saturates at 255
- first_err_vec  output  2  {i1,i0} of first mismatch
- first_err_valid  output  1  set on first mismatch of a run

Behaviour:
- Reset values (rst high at an edge): state IDLE; drv_i0=0, drv_i1=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0. Applies mid-run: the run is abandoned, no done pulse.
- States: IDLE, APPLY, SAMPLE, FINISH.
- IDLE, start=1:
  - clear err_cnt, first_err_*, pass; latch n_pass.
  - n_pass==0: go to FINISH.
  - otherwise: vec=0, sweep=0, settle_cnt=0, go to APPLY.
- APPLY: {drv_i1,drv_i0}=vec; settle_cnt increments each cycle; after SETTLE cycles go to SAMPLE.
- SAMPLE (1 cycle, drive unchanged):
  - At the closing edge compare cut_nq with TRUTH[vec]. Any value other than the expected 0/1, including X/Z in simulation, is a mismatch.
  - On mismatch: err_cnt += 1 unless already 255. If first_err_valid==0, set first_err_vec=vec and first_err_valid=1.
  - Next: if vec!=3, vec+1 and APPLY. If vec==3 and sweep!=n_pass-1, vec=0, sweep+1, APPLY. Otherwise FINISH.
- Vector order per sweep: 00,01,10,11 ({i1,i0}); each vector occupies SETTLE+1 cycles.
- FINISH (1 cycle): done=1, busy=0, pass=(err_cnt==0), including the final sample's update; drive returns to 00. Then IDLE.
- busy=1 exactly in APPLY and SAMPLE.
- Latency: start accepted at edge E0. busy is high for 4*n_pass*(SETTLE+1) cycles. done is high in the following cycle, i.e. cycle 4*n_pass*(SETTLE+1)+1 after E0. With n_pass==0, done is in cycle 1.
- start is ignored in APPLY, SAMPLE and FINISH; it is not queued.
- Results (pass, err_cnt, first_err_*) hold in IDLE until the next accepted start or reset.
- Drive outputs are registered, glitch-free, and change only on entry to APPLY or FINISH.

Test Plan:
1. Ideal nand2 on cut_nq, SETTLE=2, n_pass=1, start at E0 -> drive 00,01,10,11 for 3 cycles each; busy high cycles 1-12; done in cycle 13; pass=1, err_cnt=0, first_err_valid=0.
2. cut_nq stuck at 1, n_pass=3 -> err_cnt=3 (vector 11 each sweep); first_err_vec=2'b11, first_err_valid=1, pass=0; done in cycle 37.
3. cut_nq stuck at 0, n_pass=200 -> 600 raw mismatches, err_cnt saturates at 255; first_err_vec=2'b00; pass=0.
4. CUT is and2 (inverted output), n_pass=2 -> err_cnt=8, first_err_vec=00. Same bench with n_pass=0 -> done in cycle 1, pass=1, err_cnt=0, drive stays 00.
5. Pulse start at cycles 4 and 12 during a run -> both ignored; exactly one done pulse; results equal those of an undisturbed run.
6. rst high at cycle 5 of a run -> next cycle all outputs at reset values; no done. A subsequent start with an ideal nand2 gives pass=1, err_cnt=0.
